// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Types shared between the CPU-side memory blocks.
//   word_t          : 32-bit machine word (addresses and data)
//   ramstate_t      : status reported by the RAM each cycle
//                     FREE   - idle, no access in progress
//                     BUSY   - access accepted, data not ready yet
//                     ACCESS - access completes this cycle
//                     ERROR  - access terminated with a fault
//   RAM_ERROR_WORD  : response data returned to the requester on ERROR
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t RAM_ERROR_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
// Shares one single-ported RAM between the instruction cache and the data
// cache. Data requests win, except that an instruction request which has
// watched STARVE_MAX consecutive data grants is served next. Each access is
// IDLE (grant) -> IACC/DACC (strobe until RAM done) -> RESP (wait low for the
// owner for one cycle) -> IDLE.
//
// Ports
//   CLK, RST          : clock, synchronous active-high reset
//   iREN, iaddr       : instruction read request and word address
//   iwait, iload      : instruction wait (low = response cycle) and read data
//   dREN, dWEN        : data read / write request (both high = write)
//   daddr, dstore     : data word address and write data
//   dwait, dload      : data wait (low = response cycle) and read data
//   ramREN, ramWEN    : RAM read / write strobes (never both high)
//   ramaddr, ramstore : RAM address and write data
//   ramload, ramstate : RAM read data and status
// ----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output word_t     iload,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state_q;
    logic [2:0] starve_cnt_q;
    logic [2:0] starve_cnt_d;
    word_t      addr_q;
    word_t      store_q;
    logic       write_q;
    logic       iwait_q;
    logic       dwait_q;
    word_t      iload_q;
    word_t      dload_q;
    logic       ramren_q;
    logic       ramwen_q;

    logic       data_req;
    logic       grant_instr;
    logic       grant_data;
    logic       ram_done;
    word_t      resp_data;

    // Grant decision and starvation bookkeeping, only consumed in IDLE.
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch is inferred.
        data_req     = dREN | dWEN;
        grant_instr  = iREN && (!data_req || (starve_cnt_q == STARVE_LIM));
        grant_data   = data_req && !grant_instr;

        starve_cnt_d = starve_cnt_q;
        if (!iREN || grant_instr) begin
            starve_cnt_d = '0;
        end else if (grant_data && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end

        // A RAM fault still ends the access; the requester sees a marker word.
        ram_done  = (ramstate == ACCESS) || (ramstate == ERROR);
        resp_data = (ramstate == ERROR) ? RAM_ERROR_WORD : ramload;
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            store_q      <= '0;
            write_q      <= 1'b0;
            iwait_q      <= 1'b1;
            dwait_q      <= 1'b1;
            iload_q      <= '0;
            dload_q      <= '0;
            ramren_q     <= 1'b0;
            ramwen_q     <= 1'b0;
        end else begin
            // Waits are low for a single cycle only; default them high.
            iwait_q <= 1'b1;
            dwait_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (grant_instr) begin
                        addr_q   <= iaddr;
                        write_q  <= 1'b0;
                        ramren_q <= 1'b1;
                        state_q  <= IACC;
                    end else if (grant_data) begin
                        addr_q   <= daddr;
                        store_q  <= dstore;
                        write_q  <= dWEN;
                        ramren_q <= ~dWEN;
                        ramwen_q <= dWEN;
                        state_q  <= DACC;
                    end
                end

                // The owner is encoded by the state itself (IACC vs DACC).
                IACC, DACC: begin
                    if (ram_done) begin
                        ramren_q <= 1'b0;
                        ramwen_q <= 1'b0;
                        state_q  <= RESP;
                        if (state_q == IACC) begin
                            iload_q <= resp_data;
                            iwait_q <= 1'b0;
                        end else begin
                            if (!write_q) begin
                                dload_q <= resp_data;
                            end
                            dwait_q <= 1'b0;
                        end
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign iwait    = iwait_q;
    assign dwait    = dwait_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
// Directed scenarios against memory_arbiter with a behavioural RAM, a
// transaction-level reference model checked every cycle, and hand-computed
// literal expectations per scenario.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN;
    logic      dREN;
    logic      dWEN;
    word_t     iaddr;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     iload;
    word_t     dload;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .iload    (iload),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Contents of a never-written RAM word.
    function automatic word_t init_word(input logic [7:0] a);
        return (a == 8'h40) ? 32'hDEAD_BEEF : {24'hC0DE00, a};
    endfunction

    // ---------------- behavioural RAM ----------------
    int    ram_lat = 0;
    bit    ram_err = 1'b0;
    int    ram_cnt = 0;
    bit    ram_valid [256];
    word_t ram_data  [256];

    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN) begin
            ramstate = (ram_cnt >= ram_lat) ? (ram_err ? ERROR : ACCESS) : BUSY;
        end
        ramload = ram_err ? 32'h5EED_5EED
                : (ram_valid[ramaddr[7:0]] ? ram_data[ramaddr[7:0]] : init_word(ramaddr[7:0]));
    end

    always @(posedge CLK) begin
        if (!(ramREN || ramWEN)) ram_cnt <= 0;
        else if (ram_cnt < ram_lat) ram_cnt <= ram_cnt + 1;
        if (ramWEN && ramstate == ACCESS) begin
            ram_valid[ramaddr[7:0]] <= 1'b1;
            ram_data[ramaddr[7:0]]  <= ramstore;
        end
    end

    // ---------------- reference model ----------------
    typedef enum int { M_NONE, M_INSTR, M_DATA } who_t;
    who_t  m_busy = M_NONE;   // requester whose RAM access is in flight
    who_t  m_resp = M_NONE;   // requester receiving its response this cycle
    bit    m_write = 1'b0;
    word_t m_addr, m_store, m_iload, m_dload, m_rd;
    int    m_waits = 0;       // data grants seen while the instruction side waits
    bit    m_valid [256];
    word_t m_data  [256];

    function automatic word_t model_read(input word_t a);
        return m_valid[a[7:0]] ? m_data[a[7:0]] : init_word(a[7:0]);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_busy  = M_NONE;
            m_resp  = M_NONE;
            m_waits = 0;
            m_write = 1'b0;
            m_iload = '0;
            m_dload = '0;
        end else if (m_resp != M_NONE) begin
            m_resp = M_NONE;
        end else if (m_busy != M_NONE) begin
            if (ramstate == ACCESS || ramstate == ERROR) begin
                m_rd = (ramstate == ERROR) ? 32'hBAD1_BAD1 : model_read(m_addr);
                if (m_busy == M_INSTR) m_iload = m_rd;
                else if (!m_write) m_dload = m_rd;
                else if (ramstate == ACCESS) begin
                    m_valid[m_addr[7:0]] = 1'b1;
                    m_data[m_addr[7:0]]  = m_store;
                end
                m_resp = m_busy;
                m_busy = M_NONE;
            end
        end else if ((dREN || dWEN) && !(iREN && m_waits == STARVE_MAX)) begin
            m_busy  = M_DATA;
            m_write = dWEN;
            m_addr  = daddr;
            m_store = dstore;
            m_waits = iREN ? m_waits + 1 : 0;
        end else if (iREN) begin
            m_busy  = M_INSTR;
            m_write = 1'b0;
            m_addr  = iaddr;
            m_waits = 0;
        end else begin
            m_waits = 0;
        end
    end

    // Every-cycle comparison, mid-cycle on the falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("iwait", 32'(iwait), 32'(m_resp != M_INSTR));
            check("dwait", 32'(dwait), 32'(m_resp != M_DATA));
            check("ramREN", 32'(ramREN), 32'(m_busy != M_NONE && !m_write));
            check("ramWEN", 32'(ramWEN), 32'(m_busy != M_NONE && m_write));
            check("strobe_excl", 32'(ramREN && ramWEN), 32'd0);
            if (m_busy != M_NONE) check("ramaddr", ramaddr, m_addr);
            if (m_busy == M_DATA && m_write) check("ramstore", ramstore, m_store);
            if (m_resp == M_INSTR) check("iload", iload, m_iload);
            if (m_resp == M_DATA && !m_write) check("dload", dload, m_dload);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns the number of edges until the selected wait is seen low, 0 if never.
    task automatic wait_low(input bit instr, input int max, output int cycles);
        cycles = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (!(instr ? iwait : dwait)) begin
                cycles = k;
                return;
            end
        end
    endtask

    int c;
    int dp;

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        tick();
        chk_en = 1'b1;
        tick();
        RST = 1'b0;

        // Reset values
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);

        // Instruction read, two BUSY cycles before ACCESS
        ram_lat = 2; iaddr = 32'h40; iREN = 1'b1;
        wait_low(1'b1, 20, c);
        check("s1_latency", 32'(c), 32'd4);
        check("s1_iload", iload, 32'hDEAD_BEEF);
        iREN = 1'b0;
        tick();
        check("s1_single_pulse", 32'(iwait), 32'd1);

        // Simultaneous instruction read and data write: write goes first
        ram_lat = 1; iaddr = 32'h44; daddr = 32'h80; dstore = 32'h1234;
        iREN = 1'b1; dWEN = 1'b1;
        tick();
        check("s2_wen", 32'(ramWEN), 32'd1);
        check("s2_ren", 32'(ramREN), 32'd0);
        check("s2_addr", ramaddr, 32'h80);
        check("s2_store", ramstore, 32'h1234);
        dWEN = 1'b0;
        wait_low(1'b0, 20, c);
        check("s2_dwait_seen", 32'(c != 0), 32'd1);
        c = 0;
        for (int k = 1; k <= 10 && c == 0; k++) begin
            tick();
            if (ramREN) c = k;
        end
        check("s2_iread_start", 32'(c), 32'd2);
        check("s2_iread_addr", ramaddr, 32'h44);
        wait_low(1'b1, 20, c);
        check("s2_iload", iload, 32'hC0DE_0044);
        iREN = 1'b0;
        tick();

        // Starvation: data held continuously, 5th grant is the instruction
        ram_lat = 0; iaddr = 32'h48; daddr = 32'h80; iREN = 1'b1; dREN = 1'b1;
        dp = 0; c = 0;
        for (int k = 0; k < 60 && c == 0; k++) begin
            tick();
            if (!dwait) begin
                dp++;
                if (dp == 1) check("s3_written_word", dload, 32'h1234);
            end
            if (!iwait) c = 1;
        end
        check("s3_instr_served", 32'(c), 32'd1);
        check("s3_data_grants", 32'(dp), 32'd4);
        check("s3_iload", iload, 32'hC0DE_0048);
        iREN = 1'b0; dREN = 1'b0;
        tick();

        // RAM ERROR on a data read
        ram_err = 1'b1; ram_lat = 1; daddr = 32'h10; dREN = 1'b1;
        wait_low(1'b0, 20, c);
        check("s4_dwait_seen", 32'(c != 0), 32'd1);
        check("s4_dload", dload, 32'hBAD1_BAD1);
        dREN = 1'b0; ram_err = 1'b0;
        tick();
        check("s4_single_pulse", 32'(dwait), 32'd1);

        // Reset in the middle of a data access
        ram_lat = 5; daddr = 32'h20; dREN = 1'b1;
        tick();
        tick();
        check("s5_in_access", 32'(ramREN), 32'd1);
        RST = 1'b1;
        tick();
        check("s5_ren_dropped", 32'(ramREN), 32'd0);
        check("s5_dwait_high", 32'(dwait), 32'd1);
        RST = 1'b0; dREN = 1'b0;
        dp = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!dwait) dp++;
        end
        check("s5_no_pulse", 32'(dp), 32'd0);

        // Data requester drops mid-access; pending instruction is next
        ram_lat = 3; daddr = 32'h30; iaddr = 32'h4C; dREN = 1'b1; iREN = 1'b0;
        tick();
        check("s6_ren", 32'(ramREN), 32'd1);
        dREN = 1'b0; iREN = 1'b1;
        wait_low(1'b0, 20, c);
        check("s6_dwait_cycles", 32'(c), 32'd4);
        check("s6_dload", dload, 32'hC0DE_0030);
        tick();
        check("s6_turnaround_dwait", 32'(dwait), 32'd1);
        check("s6_turnaround_idle", 32'(ramREN), 32'd0);
        tick();
        check("s6_instr_grant", 32'(ramREN), 32'd1);
        check("s6_instr_addr", ramaddr, 32'h4C);
        wait_low(1'b1, 20, c);
        check("s6_iload", iload, 32'hC0DE_004C);
        iREN = 1'b0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the scenarios");
        $fatal(1, "watchdog expired");
    end

endmodule
